mod_exp: RTL and testbench
==========================

MOD_EXP -- requirements
Module: mod_exp

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all logic on posedge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  one-cycle request to begin an exponentiation.
REQ-004 SHALL have port: base  input  32  message or ciphertext operand.
REQ-005 SHALL have port: exponent  input  32  e_key for encryption, d_key for decryption.
REQ-006 SHALL have port: modulus  input  32  n_key.
REQ-007 SHALL have port: busy  output  1  high while a computation is in progress.
REQ-008 SHALL have port: result  output  32  base^exponent mod modulus.
REQ-009 SHALL have port: result_valid  output  1  one-cycle tick when result is updated.
REQ-010 SHALL have port: error  output  1  one-cycle tick, coincident with result_valid, when modulus == 0.

Function
REQ-011 SHALL accept start only in IDLE; start while busy SHALL be ignored with no effect.
REQ-012 SHALL latch base, exponent and modulus on the accepting edge; input changes while busy SHALL be ignored.
REQ-013 SHALL implement states IDLE, REDUCE, SQUARE, MULT and DONE.
REQ-014 Transitions SHALL be: IDLE->REDUCE on start; REDUCE->SQUARE; SQUARE->MULT if the current exponent bit is 1, else the next bit; after bit 0 ->DONE; DONE->IDLE after one cycle.
REQ-015 REDUCE SHALL compute b = base*1 mod modulus, so base >= modulus is handled.
REQ-016 The accumulator SHALL initialise to 1 and scan the exponent left to right over all 32 bits (bit 31 to 0); leading zeros SHALL NOT be skipped.
REQ-017 Each modular multiply SHALL occupy exactly 33 cycles: 1 issue cycle plus 32 shift-add iterations.
REQ-018 Latency from the accepting edge to result_valid SHALL be L = 33*(33 + popcount(exponent)) + 1 cycles.
REQ-019 Modular multiply SHALL use interleaved shift-add with a 34-bit internal accumulator; each step SHALL double the accumulator, conditionally add a, and subtract modulus until the value is below modulus; no intermediate may overflow for any modulus up to 2^32-1.
REQ-020 When modulus == 0: result SHALL be 0, error and result_valid SHALL pulse 2 cycles after start, and busy SHALL be high for exactly 1 cycle.
REQ-021 When modulus == 1, result SHALL be 0 via the normal path.
REQ-022 When exponent == 0 and modulus >= 2, result SHALL be 1.
REQ-023 busy SHALL rise on the cycle after the accepting edge and fall in the same cycle result_valid is high.
REQ-024 result SHALL hold its value until the next result_valid.

Reset
REQ-025 On rst: state SHALL be IDLE, busy=0, result=0, result_valid=0, error=0, and all internal registers SHALL be cleared.
REQ-026 rst asserted mid-computation SHALL abort it without producing a result_valid.
REQ-027 rst SHALL take priority over a coincident start.
REQ-028 The first start SHALL be accepted on the cycle after rst deasserts.

Structure
REQ-029 A shared package/include SHALL hold: KEY_W=32, the MULW=34 internal width, the MM_CYCLES=33 constant, and the state encodings.
REQ-030 Modular multiplication SHALL be a sub-module mod_mul with ports clk, rst, mm_start, a, b, n, mm_done, p, and a fixed 33-cycle latency.
REQ-031 mod_exp SHALL contain only the controller, the operand registers and the exponent shift register.

Verification
REQ-032 base=4, exponent=13, modulus=497 -> result=445; result_valid exactly 33*36+1=1189 cycles after start.
REQ-033 RSA round trip with n=3233, e=17, d=2753: encrypting m=65 -> result=2790; decrypting 2790 -> result=65.
REQ-034 base=100, exponent=3, modulus=7 -> result=1 (base reduced to 2 first); base=7, exponent=0, modulus=13 -> result=1.
REQ-035 base=2, exponent=4294967290, modulus=4294967291 -> result=1 (Fermat check; exercises the overflow margin).
REQ-036 modulus=0 -> error=1, result=0 after 2 cycles; separately, rst at cycle 500 of a 4^13 mod 497 run -> no result_valid, busy=0 next cycle, and the following start computes correctly.
REQ-037 start pulsed again while busy -> ignored; exactly one result_valid at the original L.

Source files
------------

// File: rtl/mod_exp_pkg.sv
// Shared widths, timing constants, FSM encoding and the interleaved
// shift-add step used by the modular multiplier.
package mod_exp_pkg;

  localparam int KEY_W     = 32;
  localparam int MULW      = 34;
  localparam int MM_CYCLES = 33;
  localparam int CNT_W     = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REDUCE = 3'd1,
    S_SQUARE = 3'd2,
    S_MULT   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // One iteration: double, conditionally add a, then pull back below n.
  // With acc < n and a <= n the sum stays under 3n < 2^34, so two
  // conditional subtracts always suffice.
  function automatic logic [MULW-1:0] mm_step(
    input logic [MULW-1:0]  acc,
    input logic             add_en,
    input logic [KEY_W-1:0] a,
    input logic [KEY_W-1:0] n
  );
    logic [MULW-1:0] t;
    logic [MULW-1:0] nz;
    nz = {{(MULW-KEY_W){1'b0}}, n};
    t  = {acc[MULW-2:0], 1'b0} + (add_en ? {{(MULW-KEY_W){1'b0}}, a} : '0);
    if (t >= nz) t = t - nz;
    if (t >= nz) t = t - nz;
    return t;
  endfunction

endpackage

// File: rtl/mod_exp_if.sv
// Request/response bundle for the mod_exp engine, used by the bench to
// drive and observe the core.
interface mod_exp_if;
  import mod_exp_pkg::*;

  logic             start;
  logic [KEY_W-1:0] base;
  logic [KEY_W-1:0] exponent;
  logic [KEY_W-1:0] modulus;
  logic             busy;
  logic [KEY_W-1:0] result;
  logic             result_valid;
  logic             error;

  modport master (
    output start, base, exponent, modulus,
    input  busy, result, result_valid, error
  );

  modport slave (
    input  start, base, exponent, modulus,
    output busy, result, result_valid, error
  );
endinterface

// File: rtl/mod_exp_mod_mul.sv
// Bit-serial modular multiplier: p = a*b mod n. mm_start is the issue
// cycle; p and mm_done appear exactly 33 cycles later.
module mod_mul
  import mod_exp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             mm_start,
  input  logic [KEY_W-1:0] a,
  input  logic [KEY_W-1:0] b,
  input  logic [KEY_W-1:0] n,
  output logic             mm_done,
  output logic [KEY_W-1:0] p
);

  logic [KEY_W-1:0] a_q, b_q, n_q, p_q;
  logic [MULW-1:0]  acc_q, acc_d;
  logic [4:0]       it_q;
  logic             run_q, done_q;

  // b is scanned MSB first; a is the addend and must not exceed n.
  assign acc_d = mm_step(acc_q, b_q[KEY_W-1], a_q, n_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      p_q    <= '0;
      acc_q  <= '0;
      it_q   <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (mm_start) begin
        a_q   <= a;
        b_q   <= b;
        n_q   <= n;
        acc_q <= '0;
        it_q  <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        acc_q <= acc_d;
        b_q   <= {b_q[KEY_W-2:0], 1'b0};
        it_q  <= it_q + 5'd1;
        if (it_q == 5'd31) begin
          run_q  <= 1'b0;
          p_q    <= acc_d[KEY_W-1:0];
          done_q <= 1'b1;
        end
      end
    end
  end

  assign p       = p_q;
  assign mm_done = done_q;

endmodule

// File: rtl/mod_exp.sv
// Left-to-right square-and-multiply controller around mod_mul. The done
// cycle of one multiply doubles as the issue cycle of the next.
module mod_exp
  import mod_exp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] base,
  input  logic [KEY_W-1:0] exponent,
  input  logic [KEY_W-1:0] modulus,
  output logic             busy,
  output logic [KEY_W-1:0] result,
  output logic             result_valid,
  output logic             error
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MM_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       bit_q;
  logic [KEY_W-1:0] exp_q, base_q, n_q, b_q, acc_q, result_q;
  logic             first_q, mm_start_q, busy_q, rv_q, err_q;

  logic             mm_done;
  logic [KEY_W-1:0] mm_p, mm_a, mm_b, acc_cur;

  // On a done cycle the fresh product is only in mm_p; the first done
  // belongs to REDUCE and is the reduced base, not the accumulator.
  always_comb begin
    acc_cur = (mm_done && !first_q) ? mm_p : acc_q;
    mm_a    = acc_cur;
    mm_b    = acc_cur;
    case (state_q)
      S_REDUCE: begin
        mm_a = KEY_W'(1);
        mm_b = base_q;
      end
      S_MULT: begin
        mm_a = b_q;
        mm_b = acc_cur;
      end
      default: ;
    endcase
  end

  mod_mul u_mul (
    .clk      (clk),
    .rst      (rst),
    .mm_start (mm_start_q),
    .a        (mm_a),
    .b        (mm_b),
    .n        (n_q),
    .mm_done  (mm_done),
    .p        (mm_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      exp_q      <= '0;
      base_q     <= '0;
      n_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      first_q    <= 1'b0;
      mm_start_q <= 1'b0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mm_start_q <= 1'b0;
      rv_q       <= 1'b0;
      err_q      <= 1'b0;

      if (mm_done) begin
        if (first_q) begin
          b_q     <= mm_p;
          first_q <= 1'b0;
        end else begin
          acc_q <= mm_p;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q     <= base;
            exp_q      <= exponent;
            n_q        <= modulus;
            acc_q      <= KEY_W'(1);
            first_q    <= 1'b1;
            bit_q      <= 5'd31;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            mm_start_q <= (modulus != '0);
            state_q    <= S_REDUCE;
          end
        end

        S_REDUCE: begin
          if (n_q == '0) begin
            result_q <= '0;
            rv_q     <= 1'b1;
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q      <= '0;
            mm_start_q <= 1'b1;
            state_q    <= S_SQUARE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_SQUARE, S_MULT: begin
          if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            if (state_q == S_SQUARE && exp_q[KEY_W-1]) begin
              mm_start_q <= 1'b1;
              state_q    <= S_MULT;
            end else begin
              // Current bit finished; move to the next one or wrap up.
              exp_q <= {exp_q[KEY_W-2:0], 1'b0};
              if (bit_q == 5'd0) begin
                state_q <= S_DONE;
              end else begin
                bit_q      <= bit_q - 5'd1;
                mm_start_q <= 1'b1;
                state_q    <= S_SQUARE;
              end
            end
          end
        end

        S_DONE: begin
          result_q <= mm_p;
          rv_q     <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign error        = err_q;

endmodule

// File: tb/tb_mod_exp.sv
// Directed vectors for mod_exp: known results, latency, modulus edge
// cases, reset abort and start-while-busy.
module tb_mod_exp;
  logic clk = 1'b0;
  logic rst;

  mod_exp_if bus();

  always #5 clk = ~clk;

  mod_exp dut (
    .clk          (clk),
    .rst          (rst),
    .start        (bus.start),
    .base         (bus.base),
    .exponent     (bus.exponent),
    .modulus      (bus.modulus),
    .busy         (bus.busy),
    .result       (bus.result),
    .result_valid (bus.result_valid),
    .error        (bus.error)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One transaction. cyc counts edges after the accepting edge until
  // result_valid; -1 if the cycle budget runs out.
  task automatic run_op(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                        input int poke_at,
                        output logic [31:0] res, output int cyc, output logic err,
                        output logic busy0, output logic busy_rv);
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.base = b; bus.exponent = e; bus.modulus = m;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.base = ~b; bus.exponent = ~e; bus.modulus = m + 32'd5;
    busy0 = bus.busy;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.result_valid) seen = 1'b1;
      else bus.start = (cyc == poke_at);
    end
    bus.start = 1'b0;
    res = bus.result; err = bus.error; busy_rv = bus.busy;
    if (!seen) cyc = -1;
  endtask

  task automatic do_case(input string tag, input logic [31:0] b, input logic [31:0] e,
                         input logic [31:0] m, input logic [31:0] exp_res, input int poke_at);
    logic [31:0] res;
    int cyc, lat;
    logic err, b0, brv;
    lat = (m == 0) ? 1 : 33 * (33 + $countones(e)) + 1;
    run_op(b, e, m, poke_at, res, cyc, err, b0, brv);
    chk({tag, ".result"}, res, exp_res);
    chk({tag, ".latency"}, cyc, lat);
    chk({tag, ".error"}, {31'b0, err}, {31'b0, m == 0});
    chk({tag, ".busy_rise"}, {31'b0, b0}, 32'd1);
    chk({tag, ".busy_fall"}, {31'b0, brv}, 32'd0);
    // Result must hold and nothing else may start.
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".hold"}, bus.result, exp_res);
    chk({tag, ".idle_after"}, {30'b0, bus.busy, bus.result_valid}, 32'd0);
  endtask

  initial begin
    int rv_cnt;
    rst = 1'b1;
    bus.start = 1'b0; bus.base = '0; bus.exponent = '0; bus.modulus = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy",  {31'b0, bus.busy}, 32'd0);
    chk("rst.result", bus.result, 32'd0);
    chk("rst.valid", {31'b0, bus.result_valid}, 32'd0);
    chk("rst.error", {31'b0, bus.error}, 32'd0);
    rst = 1'b0;

    do_case("mod497",   32'd4,   32'd13,   32'd497,  32'd445, 0);
    do_case("rsa_enc",  32'd65,  32'd17,   32'd3233, 32'd2790, 0);
    do_case("rsa_dec",  32'd2790, 32'd2753, 32'd3233, 32'd65, 0);
    do_case("reduce",   32'd100, 32'd3,    32'd7,    32'd1, 0);
    do_case("exp0",     32'd7,   32'd0,    32'd13,   32'd1, 0);
    do_case("fermat",   32'd2,   32'd4294967290, 32'd4294967291, 32'd1, 0);
    do_case("neg1sq",   32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 32'd1, 0);
    do_case("base_eq_n", 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd0, 0);
    do_case("mod1",     32'd5,   32'd3,    32'd1,    32'd0, 0);
    do_case("mod1_e0",  32'd5,   32'd0,    32'd1,    32'd0, 0);
    do_case("mod0",     32'd9,   32'd3,    32'd0,    32'd0, 0);
    do_case("busy_start", 32'd4, 32'd13,   32'd497,  32'd445, 600);

    // Abort at cycle 500 of a 4^13 mod 497 run.
    @(negedge clk);
    bus.start = 1'b1; bus.base = 32'd4; bus.exponent = 32'd13; bus.modulus = 32'd497;
    @(posedge clk); #1;
    bus.start = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (bus.result_valid) rv_cnt++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    if (bus.result_valid) rv_cnt++;
    chk("abort.busy", {31'b0, bus.busy}, 32'd0);
    chk("abort.result", bus.result, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 1300; i++) begin
      @(posedge clk); #1;
      if (bus.result_valid) rv_cnt++;
    end
    chk("abort.no_valid", rv_cnt, 32'd0);
    do_case("after_abort", 32'd4, 32'd13, 32'd497, 32'd445, 0);

    // Reset coincident with start wins; the start is dropped.
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.base = 32'd4; bus.exponent = 32'd13; bus.modulus = 32'd497;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    chk("rst_start.busy0", {31'b0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    chk("rst_start.busy1", {31'b0, bus.busy}, 32'd0);
    do_case("post_rst", 32'd100, 32'd3, 32'd7, 32'd1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
